branch_target_buffer: RTL and testbench

- Two-way set-associative branch target buffer feeding the fetch-side meta predictor with `Hit_BTB` / `Alt_PC_BTB` for the PC currently in IF.
- Lookup is combinational off registered state, so a hit is visible in the same cycle as `IF_PC`.
- Training happens one stage later from resolved ID-stage branch information.
- Taken branches allocate or refresh entries using per-set LRU replacement.

---
 rtl/bp_pkg.sv | 34 +++
 rtl/btb_way.sv | 56 +++++
 rtl/branch_target_buffer.sv | 112 +++++++++++
 tb/tb_branch_target_buffer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: PC geometry, BTB entry layout and
// the index/tag slicing helpers used by the BTB, gshare and meta blocks.
// Pure declarations; no ports, no state.
package bp_pkg;

    localparam int PC_W     = 32;
    localparam int WORD_OFS = 2;
    localparam int WORD_W   = PC_W - WORD_OFS;

    // Tag field is sized for the widest possible tag (one set); storage
    // keeps only the bits the chosen geometry needs.
    typedef struct packed {
        logic              valid;
        logic [WORD_W-1:0] tag;
        logic [WORD_W-1:0] target;
    } btb_entry_t;

    // Set index: word-address bits [set_bits-1:0], zero-extended.
    function automatic logic [WORD_W-1:0] pc_index(input logic [PC_W-1:0] pc,
                                                    input int unsigned     set_bits);
        logic [WORD_W-1:0] word;
        word = pc[PC_W-1:WORD_OFS];
        return word & ((WORD_W'(1) << set_bits) - WORD_W'(1));
    endfunction

    // Tag: word-address bits above the index, zero-extended.
    function automatic logic [WORD_W-1:0] pc_tag(input logic [PC_W-1:0] pc,
                                                  input int unsigned     set_bits);
        logic [WORD_W-1:0] word;
        word = pc[PC_W-1:WORD_OFS];
        return word >> set_bits;
    endfunction

endpackage

// File: rtl/btb_way.sv
// One BTB way: per-set valid/tag/target storage, two async read ports,
// one indexed write port. Valid bits clear asynchronously on RESET low;
// tags and targets are left unreset. Ports: CLK, RESET, rd_idx_a/rd_a,
// rd_idx_b/rd_b, wr_en/wr_idx/wr_entry.
module btb_way
    import bp_pkg::*;
#(
    parameter int SET_BITS = 7,
    parameter int TAG_BITS = 30 - SET_BITS
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [SET_BITS-1:0] rd_idx_a,
    output btb_entry_t          rd_a,
    input  logic [SET_BITS-1:0] rd_idx_b,
    output btb_entry_t          rd_b,
    input  logic                wr_en,
    input  logic [SET_BITS-1:0] wr_idx,
    input  btb_entry_t          wr_entry
);

    localparam int SETS = 1 << SET_BITS;

    logic [SETS-1:0]     valid;
    logic [TAG_BITS-1:0] tags    [SETS];
    logic [WORD_W-1:0]   targets [SETS];

    // Upper tag bits are always zero for this geometry and are not stored.
    logic unused_tag_hi;
    assign unused_tag_hi = ^wr_entry.tag[WORD_W-1:TAG_BITS];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_entry.valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tags[wr_idx]    <= wr_entry.tag[TAG_BITS-1:0];
            targets[wr_idx] <= wr_entry.target;
        end
    end

    always_comb begin
        rd_a.valid  = valid[rd_idx_a];
        rd_a.tag    = WORD_W'(tags[rd_idx_a]);
        rd_a.target = targets[rd_idx_a];
        rd_b.valid  = valid[rd_idx_b];
        rd_b.tag    = WORD_W'(tags[rd_idx_b]);
        rd_b.target = targets[rd_idx_b];
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Two-way set-associative BTB with per-set LRU; lookup of IF_PC is
// combinational (0 cycles), training from the ID stage lands at the next edge.
// STALL freezes all state; outputs still follow IF_PC.
// Ports: CLK, RESET (async, active-low), STALL, IF_PC -> Hit_BTB/Alt_PC_BTB,
// ID_PC/Is_Branch/Is_Taken/Alt_PC_ID for training.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int SET_BITS = 7,
    parameter int TAG_BITS = 30 - SET_BITS
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic [PC_W-1:0] IF_PC,
    input  logic [PC_W-1:0] ID_PC,
    input  logic            Is_Branch,
    input  logic            Is_Taken,
    input  logic [PC_W-1:0] Alt_PC_ID,
    output logic            Hit_BTB,
    output logic [PC_W-1:0] Alt_PC_BTB
);

    localparam int SETS = 1 << SET_BITS;

    logic [SET_BITS-1:0] if_idx, id_idx;
    logic [WORD_W-1:0]   if_tag, id_tag;

    assign if_idx = SET_BITS'(pc_index(IF_PC, SET_BITS));
    assign id_idx = SET_BITS'(pc_index(ID_PC, SET_BITS));
    assign if_tag = pc_tag(IF_PC, SET_BITS);
    assign id_tag = pc_tag(ID_PC, SET_BITS);

    btb_entry_t if_w0, if_w1, id_w0, id_w1;
    btb_entry_t wr_entry;
    logic       upd, upd_way, wr_en0, wr_en1;
    logic [SETS-1:0] lru;   // 1 = way 1 is least recently used

    logic unused_align;
    assign unused_align = ^Alt_PC_ID[WORD_OFS-1:0];

    btb_way #(.SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS)) u_way0 (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_idx_a (if_idx),
        .rd_a     (if_w0),
        .rd_idx_b (id_idx),
        .rd_b     (id_w0),
        .wr_en    (wr_en0),
        .wr_idx   (id_idx),
        .wr_entry (wr_entry)
    );

    btb_way #(.SET_BITS(SET_BITS), .TAG_BITS(TAG_BITS)) u_way1 (
        .CLK      (CLK),
        .RESET    (RESET),
        .rd_idx_a (if_idx),
        .rd_a     (if_w1),
        .rd_idx_b (id_idx),
        .rd_b     (id_w1),
        .wr_en    (wr_en1),
        .wr_idx   (id_idx),
        .wr_entry (wr_entry)
    );

    // Lookup
    logic if_hit0, if_hit1, if_way;
    assign if_hit0 = if_w0.valid && (if_w0.tag == if_tag);
    assign if_hit1 = if_w1.valid && (if_w1.tag == if_tag);
    assign Hit_BTB = if_hit0 || if_hit1;
    assign if_way  = !if_hit0;   // way 0 wins a (theoretically impossible) double hit

    always_comb begin
        Alt_PC_BTB = '0;
        if (if_hit0)      Alt_PC_BTB = {if_w0.target, 2'b00};
        else if (if_hit1) Alt_PC_BTB = {if_w1.target, 2'b00};
    end

    // Training: choose hitting way, else lowest invalid way, else LRU way.
    logic id_hit0, id_hit1;
    assign id_hit0 = id_w0.valid && (id_w0.tag == id_tag);
    assign id_hit1 = id_w1.valid && (id_w1.tag == id_tag);
    assign upd     = !STALL && Is_Branch && Is_Taken;

    always_comb begin
        upd_way = lru[id_idx];
        if (id_hit0)           upd_way = 1'b0;
        else if (id_hit1)      upd_way = 1'b1;
        else if (!id_w0.valid) upd_way = 1'b0;
        else if (!id_w1.valid) upd_way = 1'b1;
    end

    // A hit rewrites valid and tag with identical values, so one write
    // format serves refresh, fill and replacement alike.
    assign wr_entry = '{valid: 1'b1, tag: id_tag, target: Alt_PC_ID[PC_W-1:WORD_OFS]};
    assign wr_en0   = upd && !upd_way;
    assign wr_en1   = upd &&  upd_way;

    // Every case leaves the written way most recently used. An IF-hit touch
    // is dropped when the update writes the same set's LRU bit.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lru <= '0;
        end else if (!STALL) begin
            if (upd)
                lru[id_idx] <= !upd_way;
            if (Hit_BTB && !(upd && (id_idx == if_idx)))
                lru[if_idx] <= !if_way;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic [31:0] IF_PC;
    logic [31:0] ID_PC;
    logic        Is_Branch;
    logic        Is_Taken;
    logic [31:0] Alt_PC_ID;
    logic        Hit_BTB;
    logic [31:0] Alt_PC_BTB;

    int tests = 0;
    int fails = 0;

    branch_target_buffer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .STALL      (STALL),
        .IF_PC      (IF_PC),
        .ID_PC      (ID_PC),
        .Is_Branch  (Is_Branch),
        .Is_Taken   (Is_Taken),
        .Alt_PC_ID  (Alt_PC_ID),
        .Hit_BTB    (Hit_BTB),
        .Alt_PC_BTB (Alt_PC_BTB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Combinational lookup, checked 1 time unit after driving IF_PC; IF_PC
    // is parked on an empty set afterwards so no LRU touch happens by accident.
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic [31:0] tgt);
        IF_PC = pc;
        #1;
        check({tag, "_hit"}, {31'd0, Hit_BTB}, {31'd0, hit});
        check({tag, "_tgt"}, Alt_PC_BTB, tgt);
        IF_PC = 32'h0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        ID_PC     = pc;
        Alt_PC_ID = tgt;
        Is_Branch = 1'b1;
        Is_Taken  = taken;
    endtask

    task automatic idle();
        Is_Branch = 1'b0;
        Is_Taken  = 1'b0;
    endtask

    initial begin
        RESET     = 1'b0;
        STALL     = 1'b0;
        IF_PC     = 32'h0040_0100;
        ID_PC     = 32'h0;
        Is_Branch = 1'b0;
        Is_Taken  = 1'b0;
        Alt_PC_ID = 32'h0;
        #1;
        check("in_reset_hit", {31'd0, Hit_BTB}, 32'd0);
        check("in_reset_tgt", Alt_PC_BTB, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        tick();
        look("reset_lookup", 32'h0040_0100, 1'b0, 32'h0);

        // Allocate; low target bits must be dropped
        train(32'h0040_0100, 32'h0040_0203, 1'b1);
        look("alloc_same_cycle", 32'h0040_0100, 1'b0, 32'h0);
        tick(); idle();
        look("alloc_next", 32'h0040_0100, 1'b1, 32'h0040_0200);

        // Second tag in the same set fills way 1
        train(32'h0041_0100, 32'h0041_0200, 1'b1);
        tick(); idle();
        look("conf_b", 32'h0041_0100, 1'b1, 32'h0041_0200);
        look("conf_a", 32'h0040_0100, 1'b1, 32'h0040_0200);

        // Touch A via an IF hit, then a third tag evicts B
        IF_PC = 32'h0040_0100;
        tick();
        IF_PC = 32'h0;
        train(32'h0042_0100, 32'h0042_0200, 1'b1);
        tick(); idle();
        look("evict_c", 32'h0042_0100, 1'b1, 32'h0042_0200);
        look("evict_b", 32'h0041_0100, 1'b0, 32'h0);
        look("evict_a", 32'h0040_0100, 1'b1, 32'h0040_0200);

        // Retarget A; misaligned IF_PC still matches
        train(32'h0040_0100, 32'h0040_0300, 1'b1);
        tick(); idle();
        look("retgt_a", 32'h0040_0103, 1'b1, 32'h0040_0300);
        look("retgt_c", 32'h0042_0100, 1'b1, 32'h0042_0200);

        // Not-taken on C: no target change, no LRU change (way 1 stays LRU)
        train(32'h0042_0100, 32'h0040_0500, 1'b0);
        tick(); idle();
        look("nt_c", 32'h0042_0100, 1'b1, 32'h0042_0200);
        train(32'h0043_0100, 32'h0043_0200, 1'b1);
        tick(); idle();
        look("nt_d", 32'h0043_0100, 1'b1, 32'h0043_0200);
        look("nt_c_gone", 32'h0042_0100, 1'b0, 32'h0);
        look("nt_a", 32'h0040_0100, 1'b1, 32'h0040_0300);

        // Stall blocks the update
        STALL = 1'b1;
        train(32'h0050_0000, 32'h0050_0400, 1'b1);
        tick(); idle();
        STALL = 1'b0;
        look("stall_miss", 32'h0050_0000, 1'b0, 32'h0);
        train(32'h0050_0000, 32'h0050_0400, 1'b1);
        tick(); idle();
        look("unstall_hit", 32'h0050_0000, 1'b1, 32'h0050_0400);

        // Asynchronous reset between edges
        IF_PC = 32'h0040_0100;
        #1;
        check("pre_rst_hit", {31'd0, Hit_BTB}, 32'd1);
        RESET = 1'b0;
        #1;
        check("async_rst_hit", {31'd0, Hit_BTB}, 32'd0);
        check("async_rst_tgt", Alt_PC_BTB, 32'd0);
        IF_PC = 32'h0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        tick();
        look("post_rst_a", 32'h0040_0100, 1'b0, 32'h0);
        look("post_rst_d", 32'h0043_0100, 1'b0, 32'h0);
        look("post_rst_e", 32'h0050_0000, 1'b0, 32'h0);
        train(32'h0060_0000, 32'h0060_0100, 1'b1);
        tick(); idle();
        look("post_rst_alloc", 32'h0060_0000, 1'b1, 32'h0060_0100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
